// File: rtl/rx_pkg.sv
// Shared state encoding and default timing constants for the wake-up receiver sequencer.
package rx_pkg;

  localparam int DEF_BIT_PERIOD   = 10000;
  localparam int DEF_SAMPLE_POINT = 5000;
  localparam int DEF_GUARD        = 200;
  localparam int DEF_FRAME_BITS   = 8;
  localparam int DEF_TIMEOUT_BITS = 4;
  localparam int DEF_CNT_W        = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter aligned to rfin rises; fires the mid-bit shift strobe.
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int BIT_PERIOD   = DEF_BIT_PERIOD,
  parameter int SAMPLE_POINT = DEF_SAMPLE_POINT,
  parameter int GUARD        = DEF_GUARD,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_rise,
  input  logic i_clr,
  output logic o_sh_en
);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] LO_WIN     = CNT_W'(GUARD);
  localparam logic [CNT_W-1:0] HI_WIN     = CNT_W'(BIT_PERIOD - GUARD);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_realign;

  // Rises close to a bit boundary pull the timer back into phase; others are noise.
  assign w_realign = i_rise && ((r_cnt >= HI_WIN) || ((r_cnt != '0) && (r_cnt <= LO_WIN)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= ONE;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_realign) begin
      r_cnt <= ONE;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_sh_en = !i_clr && (r_cnt == SAMPLE_CNT);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame sequencer: detects the frame start, collects FRAME_BITS samples and
// reports either a complete frame or a silence timeout.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int BIT_PERIOD   = DEF_BIT_PERIOD,
  parameter int SAMPLE_POINT = DEF_SAMPLE_POINT,
  parameter int GUARD        = DEF_GUARD,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rfin,
  input  logic                  sync_state,
  output logic                  sh_en,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  timeout,
  output logic                  busy
);

  localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int ZR_W  = $clog2(TIMEOUT_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
  localparam logic [ZR_W-1:0]  ZR_LIMIT = ZR_W'(TIMEOUT_BITS);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_rfin_d;
  logic [FRAME_BITS-1:0]   r_frame;
  logic [IDX_W-1:0]        r_bit_idx;
  logic [ZR_W-1:0]         r_zero_run;
  logic [ZR_W-1:0]         w_zero_run_next;
  logic                    w_rise;
  logic                    w_start;
  logic                    w_clr;
  logic                    w_sh_en;
  logic                    w_last_bit;

  assign w_rise          = rfin & ~r_rfin_d;
  assign w_start         = en & w_rise & ((r_state == IDLE) || (r_state == DONE));
  assign w_clr           = ~en | (r_state != RUN);
  assign w_zero_run_next = sync_state ? '0 : r_zero_run + ZR_W'(1);
  assign w_last_bit      = (r_bit_idx == LAST_IDX);

  rx_bit_timer #(
    .BIT_PERIOD   (BIT_PERIOD),
    .SAMPLE_POINT (SAMPLE_POINT),
    .GUARD        (GUARD),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_rise  (w_rise),
    .i_clr   (w_clr),
    .o_sh_en (w_sh_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    frame_valid  = 1'b0;
    timeout      = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:  if (w_rise) w_state_next = RUN;
      RUN: begin
        // The final bit completes the frame even if it also ends a zero run.
        if (w_sh_en) begin
          if (w_last_bit)                       w_state_next = DONE;
          else if (w_zero_run_next == ZR_LIMIT) w_state_next = ABORT;
        end
      end
      DONE: begin
        frame_valid  = en;
        w_state_next = w_rise ? RUN : IDLE;
      end
      ABORT: begin
        timeout      = en;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (!en) w_state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rfin_d   <= 1'b0;
      r_frame    <= '0;
      r_bit_idx  <= '0;
      r_zero_run <= '0;
    end else begin
      r_rfin_d <= rfin;
      if (w_sh_en) begin
        r_frame    <= {r_frame[FRAME_BITS-2:0], sync_state};
        r_bit_idx  <= w_last_bit ? '0 : r_bit_idx + IDX_W'(1);
        r_zero_run <= w_zero_run_next;
      end else if (w_clr) begin
        r_bit_idx  <= '0;
        r_zero_run <= '0;
      end
    end
  end

  assign sh_en      = w_sh_en;
  assign frame_data = r_frame;

endmodule
